// File: rtl/dncnt_timer.sv
// Loadable down-counter/timer (IDLE/RUN/DONE) with a one-cycle done pulse; DNCNT_AUTORELOAD_EN adds periodic reload.
// All outputs are registered and load/start show one cycle after sampling; no backpressure, and inputs are ignored outside their own state.
module dncnt_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             a_reset_i,
   input  logic             s_reset_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             start_i,
   input  logic             en_i,
   input  logic             stop_i,
   output logic [WIDTH-1:0] count_o,
   output logic             busy_o,
   output logic             done_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] start_val;
`ifdef DNCNT_AUTORELOAD_EN
   logic [WIDTH-1:0] reload_q, reload_d;
`endif

   always_ff @(posedge clk_i or negedge a_reset_i) begin
      if (!a_reset_i) begin
         state_q <= S_IDLE;
         count_q <= '0;
         done_q  <= 1'b0;
`ifdef DNCNT_AUTORELOAD_EN
         reload_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         done_q  <= done_d;
`ifdef DNCNT_AUTORELOAD_EN
         reload_q <= reload_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      done_d    = 1'b0;
      start_val = load_i ? load_val_i : count_q;
`ifdef DNCNT_AUTORELOAD_EN
      reload_d  = reload_q;
`endif
      if (s_reset_i) begin
         state_d = S_IDLE;
         count_d = '0;
`ifdef DNCNT_AUTORELOAD_EN
         reload_d = '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (load_i) begin
                  count_d = load_val_i;
`ifdef DNCNT_AUTORELOAD_EN
                  reload_d = load_val_i;
`endif
               end
               // A simultaneous load decides RUN vs DONE on the new value.
               if (start_i) begin
                  if (start_val != '0) begin
                     state_d = S_RUN;
                  end else begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (stop_i) begin
                  state_d = S_IDLE;
               end else if (en_i) begin
                  if (count_q > WIDTH'(1)) begin
                     count_d = count_q - WIDTH'(1);
                  end else begin
                     done_d = 1'b1;
`ifdef DNCNT_AUTORELOAD_EN
                     if (reload_q != '0) begin
                        count_d = reload_q;
                     end else begin
                        count_d = '0;
                        state_d = S_DONE;
                     end
`else
                     count_d = '0;
                     state_d = S_DONE;
`endif
                  end
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
               count_d = '0;
            end
         endcase
      end
   end

   assign count_o = count_q;
   assign busy_o  = (state_q == S_RUN);
   assign done_o  = done_q;

endmodule

// File: tb/tb_dncnt_timer.sv
// Directed bench for dncnt_timer: stimulus queues expected outputs, a negedge monitor pops and compares.
module tb_dncnt_timer;

   localparam int WIDTH = 4;

   typedef struct {
      logic [WIDTH-1:0] cnt;
      logic             busy;
      logic             done;
      int               tag;
   } exp_t;

   logic             clk = 1'b0;
   logic             a_reset = 1'b0;
   logic             s_reset = 1'b0;
   logic             load = 1'b0;
   logic [WIDTH-1:0] load_val = '0;
   logic             start = 1'b0;
   logic             en = 1'b0;
   logic             stop = 1'b0;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             done;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   pushed = 0;
   int   tag    = 0;

   dncnt_timer #(.WIDTH(WIDTH)) dut (
      .clk_i      (clk),
      .a_reset_i  (a_reset),
      .s_reset_i  (s_reset),
      .load_i     (load),
      .load_val_i (load_val),
      .start_i    (start),
      .en_i       (en),
      .stop_i     (stop),
      .count_o    (count),
      .busy_o     (busy),
      .done_o     (done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         checks++;
         if (count !== mon_e.cnt || busy !== mon_e.busy || done !== mon_e.done) begin
            errors++;
            $display("FAIL step%0d: got count=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                     mon_e.tag, count, busy, done, mon_e.cnt, mon_e.busy, mon_e.done);
         end
      end
   end

   task automatic push_exp(input logic [WIDTH-1:0] c, input logic b, input logic d);
      exp_t e;
      tag++;
      e.cnt = c; e.busy = b; e.done = d; e.tag = tag;
      exp_q.push_back(e);
      pushed++;
   endtask

   // Expected outputs after the next rising edge; returns 1 time unit past it.
   task automatic step(input logic [WIDTH-1:0] c, input logic b, input logic d);
      @(posedge clk);
      push_exp(c, b, d);
      #1;
   endtask

   task automatic drive(input logic ld, input logic [WIDTH-1:0] v, input logic st,
                        input logic e, input logic sp);
      load = ld; load_val = v; start = st; en = e; stop = sp;
   endtask

   initial begin
      // Power-up reset held low across the first edge.
      step(0, 0, 0);
      a_reset = 1'b1;

`ifndef DNCNT_AUTORELOAD_EN
      // Basic countdown from 3.
      drive(1, 4'd3, 0, 0, 0); step(3, 0, 0);
      drive(0, 4'd0, 1, 1, 0); step(3, 1, 0);
      drive(0, 4'd0, 0, 1, 0); step(2, 1, 0);
      step(1, 1, 0);
      step(0, 0, 1);
      step(0, 0, 0);
`endif

      // Pause with en=0, then stop at 4 (stop outranks en).
      drive(1, 4'd6, 0, 0, 0); step(6, 0, 0);
      drive(0, 4'd0, 1, 1, 0); step(6, 1, 0);
      drive(0, 4'd0, 0, 1, 0); step(5, 1, 0);
      drive(0, 4'd0, 0, 0, 0); step(5, 1, 0);
      drive(0, 4'd0, 0, 1, 0); step(4, 1, 0);
      drive(0, 4'd0, 0, 1, 1); step(4, 0, 0);
      drive(0, 4'd0, 0, 1, 0); step(4, 0, 0);

      // Start with count=0, then load+start with load_val=0.
      drive(1, 4'd0, 0, 0, 0); step(0, 0, 0);
      drive(0, 4'd0, 1, 0, 0); step(0, 0, 1);
      drive(0, 4'd0, 0, 0, 0); step(0, 0, 0);
      drive(1, 4'd7, 0, 0, 0); step(7, 0, 0);
      drive(1, 4'd0, 1, 1, 0); step(0, 0, 1);
      drive(0, 4'd0, 0, 1, 0); step(0, 0, 0);
      // Load+start from count=0 must use the new value.
      drive(1, 4'd2, 1, 1, 0); step(2, 1, 0);
      drive(0, 4'd0, 0, 1, 0); step(1, 1, 0);
      drive(0, 4'd0, 0, 1, 1); step(1, 0, 0);

`ifndef DNCNT_AUTORELOAD_EN
      // Full-scale countdown, no wrap past zero.
      drive(1, 4'd15, 0, 0, 0); step(15, 0, 0);
      drive(0, 4'd0, 1, 1, 0); step(15, 1, 0);
      drive(0, 4'd0, 0, 1, 0);
      for (int k = 14; k >= 1; k--) step(4'(k), 1, 0);
      step(0, 0, 1);
      step(0, 0, 0);
      step(0, 0, 0);
`endif

      // Load ignored in RUN, then synchronous clear at count=2.
      drive(1, 4'd5, 0, 0, 0); step(5, 0, 0);
      drive(0, 4'd0, 1, 1, 0); step(5, 1, 0);
      drive(0, 4'd0, 0, 1, 0); step(4, 1, 0);
      step(3, 1, 0);
      drive(1, 4'd9, 0, 1, 0); step(2, 1, 0);
      drive(0, 4'd0, 0, 1, 0); s_reset = 1'b1; step(0, 0, 0);
      s_reset = 1'b0; step(0, 0, 0);

      // Asynchronous reset mid-cycle while running at 5.
      drive(1, 4'd5, 0, 0, 0); step(5, 0, 0);
      drive(0, 4'd0, 1, 1, 0); step(5, 1, 0);
      drive(0, 4'd0, 0, 0, 0); step(5, 1, 0);
      @(posedge clk); #1;
      a_reset = 1'b0;
      push_exp(0, 0, 0);
      step(0, 0, 0);
      a_reset = 1'b1;
      drive(1, 4'd3, 1, 1, 0); step(3, 1, 0);
      drive(0, 4'd0, 0, 1, 1); step(3, 0, 0);
      drive(0, 4'd0, 0, 0, 0);

`ifdef DNCNT_AUTORELOAD_EN
      // Periodic reload with period 2, then stop.
      drive(1, 4'd2, 0, 0, 0); step(2, 0, 0);
      drive(0, 4'd0, 1, 1, 0); step(2, 1, 0);
      drive(0, 4'd0, 0, 1, 0);
      for (int k = 0; k < 3; k++) begin
         step(1, 1, 0);
         step(2, 1, 1);
      end
      step(1, 1, 0);
      drive(0, 4'd0, 0, 1, 1); step(1, 0, 0);
      drive(0, 4'd0, 0, 0, 0); step(1, 0, 0);
`endif

      @(negedge clk); #1;
      checks++;
      if (pushed != checks - 1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d checked, %0d pending, want %0d checked, 0 pending",
                  checks - 1, exp_q.size(), pushed);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/dncnt_timer.md
# dncnt_timer

Loadable down-counter/timer with a start/stop handshake and a one-cycle terminal-count pulse. It is the decrementing counterpart to the team's up-counter. It is used as the programmable delay/interval source beside the up-counter in the homework datapath. A 3-state FSM sequences load, run and done, with optional auto-reload for periodic operation.

## Interface
Parameters:
- WIDTH, 4, counter width in bits (legal 2..16)

Ports:
- clk  input  1  rising-edge clock; the block's only clock
- a_reset  input  1  asynchronous reset, active-low; clears all state immediately
- s_reset  input  1  synchronous clear, active-high, sampled at clk rise
- load  input  1  capture load_val into count (accepted in IDLE only)
- load_val  input  WIDTH  value to load
- start  input  1  begin countdown (accepted in IDLE only)
- en  input  1  decrement enable in RUN; 0 pauses the count
- stop  input  1  abort countdown in RUN
- count  output  WIDTH  current counter value (registered)
- busy  output  1  high while in RUN
- done  output  1  one-cycle terminal-count pulse (registered)

## Operation
- FSM states: IDLE, RUN, DONE. Encoding is free; no illegal-state lockup (unused codes go to IDLE).
- Priority at each clk rise: a_reset (async) > s_reset > state logic.
- **IDLE**
  - load=1: count <= load_val.
  - start=1 and load=0: if count!=0 go RUN; else go DONE (count stays 0).
  - load=1 and start=1 together: count <= load_val; go RUN if load_val!=0, else DONE.
  - en and stop are ignored.
- **RUN**
  - Priority is stop > en.
  - stop=1: go IDLE. count holds its current value and no done pulse is produced.
  - en=1, count>1: count <= count-1.
  - en=1, count==1: count <= 0, go DONE.
  - en=0: hold.
  - load and start are ignored.
- **DONE**
  - Lasts exactly one cycle with done=1, then goes IDLE.
  - count remains 0.
  - Inputs are ignored.
- busy=1 exactly when state==RUN. done=1 exactly when state==DONE (or on the reload cycle, see Configuration).
- Arithmetic is unsigned modulo 2^WIDTH. No wrap below 0 is possible, because RUN never decrements from 0.
- **Reset**: a_reset or s_reset gives count=0, busy=0, done=0, state IDLE, reload register=0. A reset mid-RUN abandons the count with no done pulse.

## Timing
- Load latency: count shows load_val 1 cycle after load is sampled.
- Start latency: busy rises 1 cycle after start is sampled.
- Countdown length: from start sampled with count=N (N>0, en held 1):
  - count reaches 0 and done=1 at cycle N+1 after start;
  - busy is high for N cycles;
  - IDLE at N+2.
- Each en=0 cycle in RUN stretches the countdown by one cycle.
- stop takes effect at the sampling edge; busy falls the next cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- DNCNT_AUTORELOAD_EN defined:
  - Adds a WIDTH-bit reload register, written with load_val on every accepted load.
  - In RUN with en=1 and count==1: count <= reload register and the state stays RUN. done=1 for that one cycle while busy stays 1.
  - The counter therefore runs periodically until stop or reset. Period = reload value cycles (with en=1).
  - If the reload register is 0, behaviour is identical to the undefined case.
- DNCNT_AUTORELOAD_EN undefined:
  - No reload register is present.
  - Terminal count always goes DONE -> IDLE as described in Operation.

## Test plan
- **Reset**: drive a_reset=0 asynchronously mid-cycle, with count=5 and in RUN -> count=0, busy=0, done=0 immediately; start is then accepted normally after release.
- **Basic countdown**: load_val=3, load, then start, en=1 -> count 3,2,1,0; busy high 3 cycles; done high exactly 1 cycle with count=0; IDLE after.
- **Pause and stop**: load 6, start, en toggled 1,0,1; then stop at count=4 -> count holds during en=0; busy falls the cycle after stop; count stays 4; done never asserts.
- **Boundary values**:
  - start with count=0 -> done pulse next cycle, busy never asserts.
  - load+start together with load_val=0 -> same response.
  - load_val=15 (WIDTH=4) -> 15 decrements and no wrap.
- **Sync clear and ignored inputs**: s_reset=1 at count=2 in RUN -> count=0, IDLE, no done pulse. load=1 with load_val=9 during RUN -> ignored, count unaffected.
- **Auto-reload (macro defined)**: load 2, start, en=1 for 8 cycles -> count 2,1,2,1,...; done pulses every 2 cycles; busy stays 1; stop returns to IDLE.
